// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/command bus and registered result bus of the ALU
// Ports (as interface members):
//   i_opa, i_opb   operands A/B            i_cin        carry-in
//   i_ce           clock enable            i_mode       1 = arithmetic, 0 = logical
//   i_inp_valid    bit0 = A valid, bit1 = B valid
//   i_cmd          operation code
//   o_res          result (WIDTH+2 bits)   o_cout/o_oflow  carry / borrow-overflow
//   o_e/o_g/o_l    compare flags           o_err        error
// master drives the i_* side, slave (the ALU) drives the o_* side.
interface alu_if #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
);
  logic [WIDTH-1:0]  i_opa;
  logic [WIDTH-1:0]  i_opb;
  logic              i_cin;
  logic              i_ce;
  logic              i_mode;
  logic [1:0]        i_inp_valid;
  logic [CWIDTH-1:0] i_cmd;
  logic [WIDTH+1:0]  o_res;
  logic              o_cout;
  logic              o_oflow;
  logic              o_e;
  logic              o_g;
  logic              o_l;
  logic              o_err;

  modport master (
    output i_opa, i_opb, i_cin, i_ce, i_mode, i_inp_valid, i_cmd,
    input  o_res, o_cout, o_oflow, o_e, o_g, o_l, o_err
  );

  modport slave (
    input  i_opa, i_opb, i_cin, i_ce, i_mode, i_inp_valid, i_cmd,
    output o_res, o_cout, o_oflow, o_e, o_g, o_l, o_err
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - registered arithmetic/logic unit with operand wait and 3-cycle multiply
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset, highest priority
//   bus     alu_if.slave: operands, command, valid/enable in; result and flags out
module alu #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  alu_if.slave bus
);
  localparam int W2 = WIDTH + 2;
  localparam logic [W2-1:0] W2_ONE = {{(W2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MUL1, S_MUL2} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_wmode, w_wmode_nxt;
  logic [CWIDTH-1:0] r_wcmd, w_wcmd_nxt;
  logic [W2-1:0]     r_mul_res, w_mul_nxt;
  logic [W2-1:0]     r_res, w_res_nxt;
  logic              r_cout, r_oflow, r_e, r_g, r_l, r_err;
  logic              w_cout_nxt, w_oflow_nxt, w_e_nxt, w_g_nxt, w_l_nxt, w_err_nxt;

  logic [W2-1:0]      w_a, w_b, w_cin, w_add, w_addc, w_mul_prod;
  logic [2*WIDTH-1:0] w_rol_dbl, w_ror_dbl;
  int unsigned        w_cmd_n;
  logic               w_two_op, w_need_a, w_need_b, w_invalid, w_missing, w_partial, w_restart;
  logic [W2-1:0]      w_calc_res;
  logic               w_calc_cout, w_calc_oflow, w_calc_e, w_calc_g, w_calc_l, w_calc_err;

  assign w_cmd_n = 32'(bus.i_cmd);
  assign w_a     = {2'b00, bus.i_opa};
  assign w_b     = {2'b00, bus.i_opb};
  assign w_cin   = {{(W2-1){1'b0}}, bus.i_cin};
  assign w_add   = w_a + w_b;
  assign w_addc  = w_a + w_b + w_cin;
  // Rotations: shift a doubled copy so wrapped bits land in the kept half.
  assign w_rol_dbl = {bus.i_opa, bus.i_opa} << bus.i_opb[2:0];
  assign w_ror_dbl = {bus.i_opa, bus.i_opa} >> bus.i_opb[2:0];
  assign w_mul_prod = (bus.i_cmd == CWIDTH'(9)) ? (w_a + W2_ONE) * (w_b + W2_ONE)
                                                : (w_a << 1) * w_b;

  // Operand-class decode for the current command.
  always_comb begin
    w_two_op  = 1'b0;
    w_need_a  = 1'b0;
    w_need_b  = 1'b0;
    w_invalid = 1'b0;
    if (bus.i_mode) begin
      case (w_cmd_n)
        0, 1, 2, 3, 8, 9, 10: w_two_op = 1'b1;
        4, 5:                 w_need_a = 1'b1;
        6, 7:                 w_need_b = 1'b1;
        default:              w_invalid = 1'b1;
      endcase
    end else begin
      case (w_cmd_n)
        0, 1, 2, 3, 4, 5, 12, 13: w_two_op = 1'b1;
        6, 8, 9:                  w_need_a = 1'b1;
        7, 10, 11:                w_need_b = 1'b1;
        default:                  w_invalid = 1'b1;
      endcase
    end
  end

  assign w_missing = (w_need_a && !bus.i_inp_valid[0]) || (w_need_b && !bus.i_inp_valid[1]);
  assign w_partial = w_two_op && (bus.i_inp_valid != 2'b11);
  // Waiting restarts whenever we were idle or the command changed under us.
  assign w_restart = (r_state == S_IDLE) || (bus.i_mode != r_wmode) || (bus.i_cmd != r_wcmd);

  // Single-cycle result datapath.
  always_comb begin
    w_calc_res   = '0;
    w_calc_cout  = 1'b0;
    w_calc_oflow = 1'b0;
    w_calc_e     = 1'b0;
    w_calc_g     = 1'b0;
    w_calc_l     = 1'b0;
    w_calc_err   = 1'b0;
    if (w_invalid || w_missing) begin
      w_calc_err = 1'b1;
    end else if (bus.i_mode) begin
      case (w_cmd_n)
        0: begin w_calc_res = w_add;  w_calc_cout = w_add[WIDTH];  end
        1: begin w_calc_res = w_a - w_b; w_calc_oflow = (w_a < w_b); end
        2: begin w_calc_res = w_addc; w_calc_cout = w_addc[WIDTH]; end
        3: begin w_calc_res = w_a - w_b - w_cin; w_calc_oflow = (w_a < (w_b + w_cin)); end
        4: w_calc_res = w_a + W2_ONE;
        5: w_calc_res = w_a - W2_ONE;
        6: w_calc_res = w_b + W2_ONE;
        7: w_calc_res = w_b - W2_ONE;
        8: begin
          w_calc_e = (w_a == w_b);
          w_calc_g = (w_a > w_b);
          w_calc_l = (w_a < w_b);
        end
        default: w_calc_res = '0;
      endcase
    end else begin
      case (w_cmd_n)
        0:  w_calc_res = {2'b00, bus.i_opa & bus.i_opb};
        1:  w_calc_res = {2'b00, ~(bus.i_opa & bus.i_opb)};
        2:  w_calc_res = {2'b00, bus.i_opa | bus.i_opb};
        3:  w_calc_res = {2'b00, ~(bus.i_opa | bus.i_opb)};
        4:  w_calc_res = {2'b00, bus.i_opa ^ bus.i_opb};
        5:  w_calc_res = {2'b00, ~(bus.i_opa ^ bus.i_opb)};
        6:  w_calc_res = {2'b00, ~bus.i_opa};
        7:  w_calc_res = {2'b00, ~bus.i_opb};
        8:  w_calc_res = {2'b00, bus.i_opa >> 1};
        9:  w_calc_res = {2'b00, bus.i_opa << 1};
        10: w_calc_res = {2'b00, bus.i_opb >> 1};
        11: w_calc_res = {2'b00, bus.i_opb << 1};
        12: begin w_calc_res = {2'b00, w_rol_dbl[2*WIDTH-1:WIDTH]}; w_calc_err = |bus.i_opb[WIDTH-1:4]; end
        13: begin w_calc_res = {2'b00, w_ror_dbl[WIDTH-1:0]};       w_calc_err = |bus.i_opb[WIDTH-1:4]; end
        default: w_calc_res = '0;
      endcase
    end
  end

  // Next-state and next-output logic; outputs default to zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wmode_nxt = r_wmode;
    w_wcmd_nxt  = r_wcmd;
    w_mul_nxt   = r_mul_res;
    w_res_nxt   = '0;
    w_cout_nxt  = 1'b0;
    w_oflow_nxt = 1'b0;
    w_e_nxt     = 1'b0;
    w_g_nxt     = 1'b0;
    w_l_nxt     = 1'b0;
    w_err_nxt   = 1'b0;
    if (!bus.i_ce) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_MUL1: begin
          w_state_nxt = S_MUL2;
          w_res_nxt   = r_res;
        end
        S_MUL2: begin
          w_state_nxt = S_IDLE;
          w_res_nxt   = r_mul_res;
        end
        default: begin
          w_state_nxt = S_IDLE;
          if (bus.i_inp_valid == 2'b00) begin
            w_state_nxt = S_IDLE;
          end else if (w_partial) begin
            if (w_restart) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = 4'd1;
              w_wmode_nxt = bus.i_mode;
              w_wcmd_nxt  = bus.i_cmd;
            end else if (r_cnt == 4'd15) begin
              w_err_nxt = 1'b1;
            end else begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = r_cnt + 4'd1;
            end
          end else if (bus.i_mode && (w_cmd_n == 9 || w_cmd_n == 10)) begin
            // Product is captured now and released two edges later; RES holds meanwhile.
            w_state_nxt = S_MUL1;
            w_res_nxt   = r_res;
            w_mul_nxt   = w_mul_prod;
          end else begin
            w_res_nxt   = w_calc_res;
            w_cout_nxt  = w_calc_cout;
            w_oflow_nxt = w_calc_oflow;
            w_e_nxt     = w_calc_e;
            w_g_nxt     = w_calc_g;
            w_l_nxt     = w_calc_l;
            w_err_nxt   = w_calc_err;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wmode   <= 1'b0;
      r_wcmd    <= '0;
      r_mul_res <= '0;
      r_res     <= '0;
      r_cout    <= 1'b0;
      r_oflow   <= 1'b0;
      r_e       <= 1'b0;
      r_g       <= 1'b0;
      r_l       <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_wmode   <= w_wmode_nxt;
      r_wcmd    <= w_wcmd_nxt;
      r_mul_res <= w_mul_nxt;
      r_res     <= w_res_nxt;
      r_cout    <= w_cout_nxt;
      r_oflow   <= w_oflow_nxt;
      r_e       <= w_e_nxt;
      r_g       <= w_g_nxt;
      r_l       <= w_l_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.o_res   = r_res;
  assign bus.o_cout  = r_cout;
  assign bus.o_oflow = r_oflow;
  assign bus.o_e     = r_e;
  assign bus.o_g     = r_g;
  assign bus.o_l     = r_l;
  assign bus.o_err   = r_err;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for the ALU
module tb_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [15:0] obs;
  logic        bad;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(8), .CWIDTH(4)) u_if ();

  alu #(.WIDTH(8), .CWIDTH(4)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  // Observed outputs packed as {res[9:0], cout, oflow, e, g, l, err}.
  assign obs = {u_if.o_res, u_if.o_cout, u_if.o_oflow, u_if.o_e, u_if.o_g, u_if.o_l, u_if.o_err};

  function automatic logic [15:0] pk(input logic [9:0] r, input logic co, input logic ov,
                                     input logic e, input logic g, input logic l, input logic er);
    return {r, co, ov, e, g, l, er};
  endfunction

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %04h expected %04h", tag, act, exp);
    end
  endtask

  task automatic set_in(input logic m, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic [1:0] v, input logic ci);
    u_if.i_mode      = m;
    u_if.i_cmd       = c;
    u_if.i_opa       = a;
    u_if.i_opb       = b;
    u_if.i_inp_valid = v;
    u_if.i_cin       = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    u_if.i_ce = 1'b1;
    set_in(1, 0, 8'h00, 8'h00, 2'b00, 0);
    tick(); tick();
    check("reset", obs, 16'h0000);
    rst = 1'b0;

    set_in(1, 0, 8'hFF, 8'h01, 2'b11, 0); tick();
    check("add_carry", obs, pk(10'h100, 1, 0, 0, 0, 0, 0));
    set_in(1, 2, 8'hFF, 8'h00, 2'b11, 1); tick();
    check("add_cin", obs, pk(10'h100, 1, 0, 0, 0, 0, 0));
    set_in(1, 3, 8'h05, 8'h02, 2'b11, 1); tick();
    check("sub_cin", obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
    set_in(1, 3, 8'h02, 8'h02, 2'b11, 1); tick();
    check("sub_cin_borrow", obs, pk(10'h3FF, 0, 1, 0, 0, 0, 0));
    set_in(1, 5, 8'h00, 8'h00, 2'b01, 0); tick();
    check("dec_a_wrap", obs, pk(10'h3FF, 0, 0, 0, 0, 0, 0));
    set_in(1, 6, 8'h10, 8'h20, 2'b01, 0); tick();
    check("inc_b_no_b", obs, pk(10'h000, 0, 0, 0, 0, 0, 1));

    set_in(1, 8, 8'h05, 8'h09, 2'b11, 0); tick();
    check("cmp_less", obs, pk(10'h000, 0, 0, 0, 0, 1, 0));
    set_in(1, 8, 8'h09, 8'h09, 2'b11, 0); tick();
    check("cmp_equal", obs, pk(10'h000, 0, 0, 1, 0, 0, 0));
    set_in(1, 8, 8'h09, 8'h05, 2'b11, 0); tick();
    check("cmp_greater", obs, pk(10'h000, 0, 0, 0, 1, 0, 0));

    set_in(1, 1, 8'h02, 8'h07, 2'b11, 0); tick();
    check("sub_borrow", obs, pk(10'h3FB, 0, 1, 0, 0, 0, 0));
    set_in(1, 9, 8'h03, 8'h04, 2'b11, 0); tick();
    check("mul_hold1", obs, pk(10'h3FB, 0, 0, 0, 0, 0, 0));
    tick();
    check("mul_hold2", obs, pk(10'h3FB, 0, 0, 0, 0, 0, 0));
    tick();
    check("mul9_result", obs, pk(10'd20, 0, 0, 0, 0, 0, 0));
    set_in(1, 10, 8'h03, 8'h05, 2'b11, 0); tick(); tick(); tick();
    check("mul10_result", obs, pk(10'd30, 0, 0, 0, 0, 0, 0));
    set_in(1, 9, 8'h20, 8'h20, 2'b11, 0); tick(); tick(); tick();
    check("mul9_trunc", obs, pk(10'd65, 0, 0, 0, 0, 0, 0));

    set_in(0, 0, 8'hF0, 8'h3C, 2'b11, 0); tick();
    check("and", obs, pk(10'h030, 0, 0, 0, 0, 0, 0));
    set_in(0, 5, 8'hF0, 8'h3C, 2'b11, 0); tick();
    check("xnor", obs, pk(10'h033, 0, 0, 0, 0, 0, 0));
    set_in(0, 12, 8'h81, 8'hF1, 2'b11, 0); tick();
    check("rol_err", obs, pk(10'h003, 0, 0, 0, 0, 0, 1));
    set_in(0, 13, 8'h81, 8'h01, 2'b11, 0); tick();
    check("ror", obs, pk(10'h0C0, 0, 0, 0, 0, 0, 0));
    set_in(0, 6, 8'h12, 8'h34, 2'b10, 0); tick();
    check("not_a_no_a", obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
    set_in(0, 11, 8'h00, 8'h81, 2'b10, 0); tick();
    check("shl_b", obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
    set_in(1, 11, 8'h01, 8'h01, 2'b11, 0); tick();
    check("invalid_arith", obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
    set_in(0, 14, 8'h01, 8'h01, 2'b11, 0); tick();
    check("invalid_logic", obs, pk(10'h000, 0, 0, 0, 0, 0, 1));

    set_in(1, 0, 8'h02, 8'h03, 2'b01, 0);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (obs != 16'h0000) bad = 1'b1;
    end
    check("wait_quiet", {15'd0, bad}, 16'h0000);
    tick();
    check("wait_timeout", obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
    set_in(1, 0, 8'h00, 8'h00, 2'b00, 0); tick();

    set_in(1, 0, 8'h02, 8'h03, 2'b01, 0);
    tick(); tick(); tick(); tick();
    check("wait_pending", obs, 16'h0000);
    set_in(1, 0, 8'h02, 8'h03, 2'b11, 0); tick();
    check("wait_complete", obs, pk(10'd5, 0, 0, 0, 0, 0, 0));

    set_in(1, 0, 8'h01, 8'h02, 2'b11, 0); tick();
    check("pre_ce", obs, pk(10'd3, 0, 0, 0, 0, 0, 0));
    u_if.i_ce = 1'b0; tick();
    check("ce_low", obs, 16'h0000);
    u_if.i_ce = 1'b1;
    set_in(1, 0, 8'h01, 8'h02, 2'b11, 0); tick();
    check("pre_valid0", obs, pk(10'd3, 0, 0, 0, 0, 0, 0));
    set_in(1, 0, 8'h01, 8'h02, 2'b00, 0); tick();
    check("valid_00", obs, 16'h0000);

    set_in(1, 0, 8'h01, 8'h02, 2'b11, 0); tick();
    set_in(1, 9, 8'h03, 8'h04, 2'b11, 0); tick();
    check("mul_before_rst", obs, pk(10'd3, 0, 0, 0, 0, 0, 0));
    rst = 1'b1; tick();
    check("rst_mid_mul", obs, 16'h0000);
    rst = 1'b0;
    set_in(1, 9, 8'h03, 8'h04, 2'b00, 0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs != 16'h0000) bad = 1'b1;
    end
    check("no_late_mul", {15'd0, bad}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
